// File: rtl/obi_slow_mem_responder.sv
// ---------------------------------------------------------------------------
// obi_slow_mem_responder
//
// OBI slave that behaves like a deliberately slow memory. Word-addressed SRAM
// (byte-lane write enables) behind a fixed-latency response pipeline that
// allows at most MAX_OUTSTANDING transactions in flight. Used to exercise
// initiator gnt/rvalid handling against a slow slave.
//
// Optional feature (compile-time macro SLOW_MEM_RANDOM_STALL_EN):
//   a 16-bit Fibonacci LFSR (taps 16,14,13,11, reset value LFSR_SEED) gates
//   gnt_o with lfsr[0] to produce random grant stalls. Latency after
//   acceptance is not affected.
//
// Ports:
//   clk_i     in   1   clock
//   rst_i     in   1   asynchronous active-high reset
//   req_i     in   1   OBI request
//   gnt_o     out  1   OBI grant (combinational)
//   addr_i    in   32  byte address, bits [AW+1:2] select the word
//   we_i      in   1   1 = write, 0 = read
//   be_i      in   4   byte enables (writes only)
//   wdata_i   in   32  write data
//   rvalid_o  out  1   response valid, one-cycle pulse per transaction
//   rdata_o   out  32  read data while rvalid_o=1, otherwise 0
//   busy_o    out  1   at least one transaction outstanding
// ---------------------------------------------------------------------------
module obi_slow_mem_responder #(
    parameter int unsigned NUM_WORDS       = 128,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [AW-1:0] word_idx;
    logic          accept;
    logic          stall_ok;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_resp;

    // Address bits outside the word index are ignored, so addresses alias
    // modulo the memory size.
    assign word_idx = addr_i[AW+1:2];

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    // -----------------------------------------------------------------------
    // Optional random grant stall
    // -----------------------------------------------------------------------
`ifdef SLOW_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign stall_ok = lfsr_reg[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall_ok    = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Grant and outstanding count
    // -----------------------------------------------------------------------
    // A response leaving this cycle frees its slot for a request arriving in
    // the same cycle, so the occupancy test uses the count minus rvalid_o.
    // rvalid_o=1 implies count_reg>=1, so the subtraction cannot underflow.
    always_comb begin
        count_after_resp = count_reg - CW'(rvalid_o);
        gnt_o            = req_i && (count_after_resp < MAX_CNT) && stall_ok;
        accept           = gnt_o;
        count_next       = count_after_resp + CW'(accept);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy_o = (count_reg != '0);

    // -----------------------------------------------------------------------
    // Memory: one byte-wide array per lane so each lane infers a plain block
    // RAM with its own write enable. Not reset; contents survive rst_i.
    // The registered read port only updates on an accepted read, and the
    // lane's write happens in a different cycle, so the old-data read
    // semantics of the RAM never matter.
    // -----------------------------------------------------------------------
    logic [31:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [NUM_WORDS];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge clk_i) begin
                if (accept && we_i && be_i[gi]) begin
                    mem_lane[word_idx] <= wdata_i[gi*8 +: 8];
                end
                if (accept && !we_i) begin
                    rd_lane_reg <= mem_lane[word_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Response pipeline. Stage 0 holds only flags; its data is the RAM read
    // register, masked to 0 for writes and bubbles. Stages 1..LATENCY-1 are
    // plain {valid,data} shift registers, all cleared by reset so in-flight
    // responses vanish.
    // -----------------------------------------------------------------------
    logic                    valid0_reg;
    logic                    read0_reg;
    logic [LATENCY-1:0]      pipe_valid;
    logic [32*LATENCY-1:0]   pipe_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid0_reg <= 1'b0;
            read0_reg  <= 1'b0;
        end else begin
            valid0_reg <= accept;
            read0_reg  <= accept && !we_i;
        end
    end

    assign pipe_valid[0]    = valid0_reg;
    assign pipe_data[31:0]  = read0_reg ? rd_word : 32'h0;

    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_stage
            logic        valid_reg;
            logic [31:0] data_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg <= 1'b0;
                    data_reg  <= 32'h0;
                end else begin
                    valid_reg <= pipe_valid[gi-1];
                    data_reg  <= pipe_data[(gi-1)*32 +: 32];
                end
            end

            assign pipe_valid[gi]          = valid_reg;
            assign pipe_data[gi*32 +: 32]  = data_reg;
        end
    endgenerate

    assign rvalid_o = pipe_valid[LATENCY-1];
    assign rdata_o  = pipe_data[(LATENCY-1)*32 +: 32];

endmodule

// File: tb/tb_obi_slow_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for obi_slow_mem_responder (default parameters, no random stall).
// A table of transactions is issued back-to-back; each grant pushes the
// expected response (data and due cycle) to a scoreboard queue, and a
// monitor pops and compares on every rvalid_o. Hand-written sequences cover
// the grant-throttling pattern and reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_obi_slow_mem_responder;

    localparam int LAT  = 4;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    obi_slow_mem_responder #(
        .NUM_WORDS      (128),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h with nothing outstanding (cycle %0d)", rdata, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdata", rdata, e.data);
                    check("latency", 32'(cyc), 32'(e.due));
                    $display("resp cycle=%0d rdata=%h expected=%h due=%0d", cyc, rdata, e.data, e.due);
                end
            end else begin
                check("rdata_idle_zero", rdata, 32'h0);
            end
        end
    end

    // Drive one transaction starting at posedge+1; wait (bounded) for grant.
    // Leaves the bench at posedge+1 of the cycle after acceptance, req still high.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] exp);
        bit done = 0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (gnt) begin
                sb.push_back('{data: exp, due: cyc + LAT});
                $display("req  cycle=%0d we=%0b addr=%h be=%h wdata=%h", cyc, w, a, b, d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no gnt for addr %h required gnt within 50 cycles", a);
        end
    endtask

    task automatic drain();
        bit idle = 0;
        req = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            if (sb.size() == 0 && !busy) idle = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending busy=%0b required 0 pending", sb.size(), busy);
        end
    endtask

    initial begin
        logic [31:0] pat_addr [6];
        logic [31:0] pat_data [6];
        logic        pat_gnt  [10];
        int k;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0014, 4'h5, 32'hAABB_CCDD, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h5A5A_5A5A, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,         32'h5A5A_5A5A};
        vecs[7]  = '{1'b1, 32'h0000_007C, 4'hF, 32'h0102_0304, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_007F, 4'h8, 32'hFF00_0000, 32'h0};
        vecs[9]  = '{1'b0, 32'h0001_007C, 4'h0, 32'h0,         32'hFF02_0304};
        vecs[10] = '{1'b1, 32'h0000_01FC, 4'hF, 32'h0BAD_F00D, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_01FC, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_01FC, 4'hF, 32'h0,         32'h0BAD_F00D};
        vecs[13] = '{1'b1, 32'h0000_0004, 4'hF, 32'h4444_4444, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0008, 4'hF, 32'h8888_8888, 32'h0};
        vecs[15] = '{1'b1, 32'h0000_000C, 4'hF, 32'hCCCC_CCCC, 32'h0};
        vecs[16] = '{1'b0, 32'h0000_000C, 4'h3, 32'h0,         32'hCCCC_CCCC};

        pat_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        pat_data = '{32'h5A5A_5A5A, 32'h4444_4444, 32'h8888_8888,
                     32'hCCCC_CCCC, 32'hDEAD_BEEF, 32'h11BB_33DD};
        pat_gnt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_rdata",  rdata,       32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_gnt",    32'(gnt),    32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_gnt_noreq", 32'(gnt),  32'h0);
        check("idle_busy",      32'(busy), 32'h0);
        check("idle_rvalid",    32'(rvalid), 32'h0);

        // Table of transactions, issued back-to-back.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp);
        end
        drain();

        // Grant throttling with req held high: MAXO=2, LAT=4.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            req  = 1'b1;
            we   = 1'b0;
            be   = 4'hF;
            addr = pat_addr[(k < 6) ? k : 5];
            #1;
            check($sformatf("gnt_pattern_%0d", i), 32'(gnt), 32'(pat_gnt[i]));
            if (gnt && k < 6) begin
                sb.push_back('{data: pat_data[k], due: cyc + LAT});
                $display("req  cycle=%0d we=0 addr=%h (throttle)", cyc, addr);
                k++;
            end
            @(posedge clk);
            #1;
        end
        drain();

        // Reset two cycles after the first of two accepted reads.
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h00, 4'hF, 32'h0, 32'h5A5A_5A5A);
        req = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_reset_busy",   32'(busy),   32'h0);
        check("post_reset_rvalid", 32'(rvalid), 32'h0);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h10;
        #1;
        check("post_reset_gnt", 32'(gnt), 32'h1);
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h04, 4'hF, 32'h0, 32'h4444_4444);
        req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obi_slow_mem_responder.md
Name: obi_slow_mem_responder

Overview:
- OBI slave responder modelling the testbench "slow memory" on the external crossbar slave port.
- Answers initiators such as the memcopy controller's master port and the CPU through the external crossbar.
- Word-addressed SRAM behind a fixed-latency, bounded-outstanding response pipeline; exercises initiator gnt/rvalid handling under slow-slave conditions.

Parameters:
- NUM_WORDS, 128, memory depth in 32-bit words (0x200 bytes); power of two, >=2.
- LATENCY, 4, cycles from accepted request (gnt) to rvalid; 1..16.
- MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions; 1..LATENCY.
- LFSR_SEED, 16'hACE1, stall LFSR reset value; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address; bits [AW+1:2] index the array, AW=$clog2(NUM_WORDS).
- we_i  in  1  1=write, 0=read.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one-cycle pulse.
- rdata_o  out  32  read data, valid while rvalid_o=1.
- busy_o  out  1  outstanding count nonzero.

Behaviour:
- Clock/reset: one clock clk_i; rst_i is asynchronous, active-high.
- Reset values: rvalid_o=0, rdata_o=0, busy_o=0, outstanding count=0, response pipeline empty. Memory array is not reset; contents persist across reset.
- Grant (combinational): gnt_o = req_i && ((count - rvalid_o) < MAX_OUTSTANDING), further gated by the optional stall.
- Accept: a transaction is accepted in cycle T iff req_i && gnt_o at the rising edge ending T. Address, we, be and wdata are sampled then.
- Write: bytes with be_i[k]=1 are committed at the accept edge; bytes with be_i[k]=0 are unchanged. be_i=0 is a no-op write but still produces a response.
- Read: data is captured at the accept edge from the array state before that edge. A read accepted after a write to the same word returns the written data. be_i is ignored for reads; the full word is returned.
- Response pipeline: LATENCY-stage shift register of {valid, data}.
  - rvalid_o=1 in exactly cycle T+LATENCY for the transaction accepted in T.
  - Responses are strictly in order, with no gaps beyond those at acceptance.
  - Writes return rdata_o=0.
  - When rvalid_o=0, rdata_o is held at 0.
- There is no rready: the initiator must accept the response in that cycle.
- Outstanding count:
  - +1 on accept, -1 on rvalid_o; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
  - Width $clog2(MAX_OUTSTANDING+1).
- Full condition: count==MAX_OUTSTANDING and rvalid_o=0 gives gnt_o=0. If rvalid_o=1 in the same cycle, the slot is reused and gnt_o may be 1.
- Address wrap: upper bits [31:AW+2] and [1:0] are ignored, so addresses alias modulo NUM_WORDS*4. No error response.
- Steady state: back-to-back requests with MAX_OUTSTANDING>=LATENCY sustain 1 transaction/cycle. Otherwise throughput is MAX_OUTSTANDING per LATENCY cycles.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset release) and count returns to 0. Writes already accepted remain in memory.
- busy_o = (count != 0), registered-count based.

Optional Feature:
- Macro: SLOW_MEM_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; resets to LFSR_SEED.
  - gnt_o is additionally ANDed with lfsr[0], giving random grant stalls.
  - Latency after acceptance is unchanged.
- Undefined: no LFSR; gnt_o depends only on req_i and count.

Test Plan:
- Reset then idle -> rvalid_o=0, rdata_o=0, gnt_o=0 with req_i=0, busy_o=0.
- Write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 (LATENCY=4) -> read accepted at T, rvalid_o=1 at T+4 with rdata_o=0xDEADBEEF. Write response at its T+4 has rdata_o=0.
- Write 0x11223344 to word 5 with be 4'hF; write 0xAABBCCDD with be 4'b0101; read -> 0x11BB33DD.
- req_i held high, reads to 0x0,0x4,0x8,0xC (MAX_OUTSTANDING=2, LATENCY=4):
  - gnt in cycles 0,1; gnt_o=0 in cycles 2,3; gnt in cycles 4,5 (reuse on rvalid).
  - rvalid in cycles 4,5,8,9, responses in order.
- Read addr 0x200 after writing 0x5A5A5A5A to addr 0x0 -> returns 0x5A5A5A5A (alias wrap).
- Two reads accepted, rst_i pulsed 1 cycle at T+2 -> no rvalid_o ever seen for them, count=0, gnt_o=1 immediately after release. Memory write done before reset still reads back.
